// File: rtl/epath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : epath_pkg
// Purpose  : Shared code-field constants, comma symbol and serialiser state
//            type for the upstream e-path TX FIFO/serialiser.
// Revision : 1.0 - initial release
// ============================================================================
package epath_pkg;

  // Two-bit code field carried with every word and every emitted symbol
  localparam logic [1:0] CODE_SOP   = 2'b10;
  localparam logic [1:0] CODE_EOP   = 2'b01;
  localparam logic [1:0] CODE_DATA  = 2'b00;
  localparam logic [1:0] CODE_COMMA = 2'b11;

  // Idle / comma symbol sent whenever no data byte is available
  localparam logic [9:0] COMMA_SYM = 10'b11_0000_0000;

  // Serialiser state: waiting for a word, or walking the bytes of one
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SER  = 1'b1
  } ser_state_t;

endpackage : epath_pkg
`default_nettype wire

// File: rtl/epath_sc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : epath_sc_fifo
// Purpose  : Single-clock circular word buffer with occupancy count, full,
//            programmable-full, empty and overflow indications.
// Revision : 1.0 - initial release
// ============================================================================
module epath_sc_fifo #(
  parameter int WIDTH            = 18,
  parameter int DEPTH            = 1024,
  parameter int PROG_FULL_THRESH = 1008
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_prog_full,
  output logic                     o_overflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth  = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_thresh = c_cw'(PROG_FULL_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_cw-1:0]  r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_prog_full;
  logic             r_overflow;

  logic             w_wr_acc;
  logic             w_pop_acc;
  logic [c_cw-1:0]  w_count_nxt;

  // Full/empty come from the registered count, so a write while full is
  // dropped even when a pop happens in the same cycle.
  assign w_wr_acc  = i_wr_en && !r_full  && !i_flush;
  assign w_pop_acc = i_pop   && !r_empty && !i_flush;

  // Next occupancy; flush wins over any simultaneous write or pop
  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_wr_acc && !w_pop_acc) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr_acc && w_pop_acc) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage array: no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointers, count and flags; flags are derived from next-state count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_prog_full <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop_acc) begin
          r_rptr <= r_rptr + 1'b1;
        end
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == c_depth);
      r_empty     <= (w_count_nxt == '0);
      r_prog_full <= (w_count_nxt >= c_thresh);
      r_overflow  <= i_wr_en && r_full && !i_flush;
    end
  end

  assign o_head      = r_mem[r_rptr];
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_prog_full = r_prog_full;
  assign o_overflow  = r_overflow;

endmodule : epath_sc_fifo
`default_nettype wire

// File: rtl/epath_tx_fifo_ser.sv
`default_nettype none
// ============================================================================
// Module   : epath_tx_fifo_ser
// Purpose  : Upstream e-path TX buffer: stores code-tagged words and
//            serialises them MSB byte first into 10-bit {code,byte} symbols
//            on single-cycle read requests, sending comma when idle.
// Revision : 1.0 - initial release
// ============================================================================
module epath_tx_fifo_ser
  import epath_pkg::*;
#(
  parameter int         DATA_WIDTH       = 16,
  parameter int         DEPTH            = 1024,
  parameter int         PROG_FULL_THRESH = 1008,
  parameter logic [9:0] COMMA            = COMMA_SYM,
  parameter int         MODULE_ENABLE    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_fifo_flush,
  input  logic                     i_wr_en,
  input  logic [DATA_WIDTH+1:0]    i_din,
  input  logic                     i_rd_en,
  output logic [9:0]               o_dout,
  output logic                     o_dout_rdy,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_prog_full,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_nbytes = DATA_WIDTH / 8;
  localparam int c_iw     = $clog2(c_nbytes);
  localparam logic [c_iw-1:0] c_last_idx = c_iw'(c_nbytes - 1);

  generate
    if (MODULE_ENABLE != 0) begin : g_enabled

      logic [DATA_WIDTH+1:0] w_head;
      logic                  w_fifo_empty;
      logic                  w_pop;

      ser_state_t            r_state;
      ser_state_t            w_state_nxt;
      logic [c_iw-1:0]       r_idx;
      logic [c_iw-1:0]       w_idx_nxt;
      logic [DATA_WIDTH+1:0] r_hold;
      logic [DATA_WIDTH+1:0] w_hold_nxt;
      logic [9:0]            r_dout;
      logic [9:0]            w_dout_nxt;
      logic                  r_dout_rdy;
      logic                  w_dout_rdy_nxt;

      logic [1:0]            w_code;
      logic [DATA_WIDTH-1:0] w_payload;
      logic                  w_last_byte;
      logic                  w_word_done;
      logic [7:0]            w_byte;
      logic [9:0]            w_sym;

      epath_sc_fifo #(
        .WIDTH            (DATA_WIDTH + 2),
        .DEPTH            (DEPTH),
        .PROG_FULL_THRESH (PROG_FULL_THRESH)
      ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_fifo_flush),
        .i_wr_en     (i_wr_en),
        .i_din       (i_din),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (w_fifo_empty),
        .o_prog_full (o_prog_full),
        .o_overflow  (o_overflow)
      );

      assign w_code      = r_hold[DATA_WIDTH+1:DATA_WIDTH];
      assign w_payload   = r_hold[DATA_WIDTH-1:0];
      assign w_last_byte = (r_idx == c_last_idx);
      // A comma-coded word is consumed by a single read
      assign w_word_done = (w_code == CODE_COMMA) || w_last_byte;

      // Select byte idx of the held payload, most significant byte first
      always_comb begin
        w_byte = 8'h00;
        for (int b = 0; b < c_nbytes; b++) begin
          if (r_idx == c_iw'(c_nbytes - 1 - b)) begin
            w_byte = w_payload[b*8 +: 8];
          end
        end
      end

      // Build the outgoing symbol: SOP tags byte 0, EOP tags the last byte
      always_comb begin
        w_sym = {CODE_DATA, w_byte};
        case (w_code)
          CODE_COMMA: w_sym = COMMA;
          CODE_SOP:   w_sym = {((r_idx == '0) ? CODE_SOP : CODE_DATA), w_byte};
          CODE_EOP:   w_sym = {(w_last_byte ? CODE_EOP : CODE_DATA), w_byte};
          default:    w_sym = {CODE_DATA, w_byte};
        endcase
      end

      // Serialiser next-state, pop request and output-register next values
      always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_hold_nxt     = r_hold;
        w_pop          = 1'b0;
        w_dout_nxt     = r_dout;
        w_dout_rdy_nxt = 1'b0;
        if (i_fifo_flush) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_dout_nxt  = COMMA;
        end else begin
          case (r_state)
            IDLE: begin
              if (i_rd_en) begin
                w_dout_nxt     = COMMA;
                w_dout_rdy_nxt = 1'b1;
              end
              if (!w_fifo_empty) begin
                w_pop       = 1'b1;
                w_hold_nxt  = w_head;
                w_idx_nxt   = '0;
                w_state_nxt = SER;
              end
            end
            SER: begin
              if (i_rd_en) begin
                w_dout_nxt     = w_sym;
                w_dout_rdy_nxt = 1'b1;
                if (w_word_done) begin
                  w_idx_nxt = '0;
                  // Chain straight into the next word to avoid a comma bubble
                  if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_hold_nxt = w_head;
                  end else begin
                    w_state_nxt = IDLE;
                  end
                end else begin
                  w_idx_nxt = r_idx + 1'b1;
                end
              end
            end
            default: begin
              w_state_nxt = IDLE;
            end
          endcase
        end
      end

      // Serialiser state, holding register and registered symbol output
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state    <= IDLE;
          r_idx      <= '0;
          r_hold     <= '0;
          r_dout     <= COMMA;
          r_dout_rdy <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_idx      <= w_idx_nxt;
          r_hold     <= w_hold_nxt;
          r_dout     <= w_dout_nxt;
          r_dout_rdy <= w_dout_rdy_nxt;
        end
      end

      assign o_dout     = r_dout;
      assign o_dout_rdy = r_dout_rdy;
      assign o_empty    = w_fifo_empty && (r_state == IDLE);

    end else begin : g_disabled

      assign o_dout      = '0;
      assign o_dout_rdy  = 1'b0;
      assign o_full      = 1'b0;
      assign o_empty     = 1'b1;
      assign o_prog_full = 1'b0;
      assign o_overflow  = 1'b0;
      assign o_count     = '0;

    end
  endgenerate

endmodule : epath_tx_fifo_ser
`default_nettype wire

// File: tb/tb_epath_tx_fifo_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_epath_tx_fifo_ser
// Purpose  : Scoreboard bench for epath_tx_fifo_ser (16-bit/1024-deep and
//            32-bit/16-deep configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_epath_tx_fifo_ser;

  localparam logic [9:0] c_comma = 10'b11_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1: default configuration ----------------
  logic        rst = 1'b1;
  logic        flush1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [17:0] din1 = '0;
  logic [9:0]  dout1;
  logic        rdy1, full1, empty1, pfull1, ovf1;
  logic [10:0] cnt1;

  epath_tx_fifo_ser u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .i_fifo_flush (flush1),
    .i_wr_en      (wr1),
    .i_din        (din1),
    .i_rd_en      (rd1),
    .o_dout       (dout1),
    .o_dout_rdy   (rdy1),
    .o_full       (full1),
    .o_empty      (empty1),
    .o_prog_full  (pfull1),
    .o_overflow   (ovf1),
    .o_count      (cnt1)
  );

  // ---------------- DUT 2: 32-bit payload, 16 deep ----------------
  logic        rst2 = 1'b1;
  logic        flush2 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
  logic [33:0] din2 = '0;
  logic [9:0]  dout2;
  logic        rdy2, full2, empty2, pfull2, ovf2;
  logic [4:0]  cnt2;

  epath_tx_fifo_ser #(
    .DATA_WIDTH       (32),
    .DEPTH            (16),
    .PROG_FULL_THRESH (12)
  ) u_dut2 (
    .clk          (clk),
    .rst          (rst2),
    .i_fifo_flush (flush2),
    .i_wr_en      (wr2),
    .i_din        (din2),
    .i_rd_en      (rd2),
    .o_dout       (dout2),
    .o_dout_rdy   (rdy2),
    .o_full       (full2),
    .o_empty      (empty2),
    .o_prog_full  (pfull2),
    .o_overflow   (ovf2),
    .o_count      (cnt2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rdy_pulses1 = 0;

  logic [9:0] sb1[$];
  logic [9:0] sb2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected symbols of a 16-bit word into DUT 1's scoreboard
  task automatic push16(input logic [1:0] code, input logic [15:0] pl);
    case (code)
      2'b11: sb1.push_back(c_comma);
      2'b10: begin sb1.push_back({2'b10, pl[15:8]}); sb1.push_back({2'b00, pl[7:0]}); end
      2'b01: begin sb1.push_back({2'b00, pl[15:8]}); sb1.push_back({2'b01, pl[7:0]}); end
      default: begin sb1.push_back({2'b00, pl[15:8]}); sb1.push_back({2'b00, pl[7:0]}); end
    endcase
  endtask

  // Single-cycle write into DUT 1
  task automatic write1(input logic [1:0] code, input logic [15:0] pl);
    wr1  = 1'b1;
    din1 = {code, pl};
    push16(code, pl);
    tick();
    wr1 = 1'b0;
  endtask

  task automatic read1(input int n);
    rd1 = 1'b1;
    repeat (n) tick();
    rd1 = 1'b0;
  endtask

  // Scoreboard monitors: every dout_rdy pops one expected symbol (comma when none pending)
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && rdy1) begin
      rdy_pulses1++;
      e = (sb1.size() != 0) ? sb1.pop_front() : c_comma;
      chk("dut1_dout", 32'(dout1), 32'(e));
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst2 && rdy2) begin
      e = (sb2.size() != 0) ? sb2.pop_front() : c_comma;
      chk("dut2_dout", 32'(dout2), 32'(e));
    end
  end

  initial begin
    int ec;
    int p0;

    // ---- reset values ----
    #12;
    chk("rst_dout",  32'(dout1),  32'(c_comma));
    chk("rst_rdy",   32'(rdy1),   32'd0);
    chk("rst_full",  32'(full1),  32'd0);
    chk("rst_empty", 32'(empty1), 32'd1);
    chk("rst_pfull", 32'(pfull1), 32'd0);
    chk("rst_ovf",   32'(ovf1),   32'd0);
    chk("rst_count", 32'(cnt1),   32'd0);
    tick();
    rst  = 1'b0;
    rst2 = 1'b0;
    tick();

    // ---- idle reads give commas ----
    p0 = rdy_pulses1;
    read1(3);
    tick();
    chk("idle_pulses", 32'(rdy_pulses1 - p0), 32'd3);
    chk("idle_empty",  32'(empty1), 32'd1);

    // ---- SOP word then EOP word, back to back ----
    write1(2'b10, 16'hA5C3);
    write1(2'b01, 16'h1234);
    tick(); tick();
    chk("two_word_empty", 32'(empty1), 32'd0);
    read1(5);
    tick();
    chk("two_word_sb", 32'(sb1.size()), 32'd0);
    chk("two_word_empty_after", 32'(empty1), 32'd1);

    // ---- fill to full with prog_full threshold and overflow ----
    for (int k = 1; k <= 1025; k++) begin
      wr1  = 1'b1;
      din1 = {2'b00, 16'(k) ^ 16'h5A00};
      push16(2'b00, 16'(k) ^ 16'h5A00);
      tick();
      ec = (k == 1) ? 1 : k - 1;
      if (ec == 1007 || ec == 1008 || ec == 1023 || ec == 1024) begin
        chk("fill_count", 32'(cnt1),   32'(ec));
        chk("fill_pfull", 32'(pfull1), (ec >= 1008) ? 32'd1 : 32'd0);
        chk("fill_full",  32'(full1),  (ec == 1024) ? 32'd1 : 32'd0);
      end
    end
    din1 = {2'b00, 16'hDEAD};
    tick();
    wr1 = 1'b0;
    chk("ovf_pulse", 32'(ovf1),  32'd1);
    chk("ovf_count", 32'(cnt1),  32'd1024);
    chk("ovf_full",  32'(full1), 32'd1);
    tick();
    chk("ovf_clear", 32'(ovf1),  32'd0);
    read1(2 * 1025 + 1);
    tick();
    chk("drain_sb",    32'(sb1.size()), 32'd0);
    chk("drain_count", 32'(cnt1),   32'd0);
    chk("drain_empty", 32'(empty1), 32'd1);
    chk("drain_full",  32'(full1),  32'd0);
    chk("drain_pfull", 32'(pfull1), 32'd0);

    // ---- comma-coded word consumed by a single read ----
    write1(2'b11, 16'hFFFF);
    write1(2'b00, 16'h5A6B);
    tick(); tick();
    read1(3);
    tick();
    chk("comma_word_sb", 32'(sb1.size()), 32'd0);

    // ---- flush mid-word ----
    write1(2'b00, 16'hBEEF);
    tick(); tick();
    rd1 = 1'b1;
    tick();
    flush1 = 1'b1;
    wr1    = 1'b1;
    din1   = {2'b10, 16'h7777};
    tick();
    flush1 = 1'b0;
    wr1    = 1'b0;
    rd1    = 1'b0;
    chk("flush_rdy",   32'(rdy1),   32'd0);
    chk("flush_dout",  32'(dout1),  32'(c_comma));
    chk("flush_count", 32'(cnt1),   32'd0);
    chk("flush_empty", 32'(empty1), 32'd1);
    sb1.delete();
    tick(); tick();
    read1(1);
    tick();
    chk("post_flush_empty", 32'(empty1), 32'd1);

    // ---- 32-bit configuration ----
    wr2  = 1'b1;
    din2 = {2'b10, 32'h0102_0304};
    sb2.push_back({2'b10, 8'h01});
    sb2.push_back({2'b00, 8'h02});
    sb2.push_back({2'b00, 8'h03});
    sb2.push_back({2'b00, 8'h04});
    tick();
    wr2 = 1'b0;
    tick(); tick();
    rd2 = 1'b1;
    repeat (4) tick();
    rd2 = 1'b0;
    tick();
    chk("w32_sb", 32'(sb2.size()), 32'd0);

    // ---- async reset mid-serialisation ----
    wr2  = 1'b1;
    din2 = {2'b00, 32'h0A0B_0C0D};
    tick();
    wr2 = 1'b0;
    tick(); tick();
    rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    chk("w32_byte0_rdy",  32'(rdy2),   32'd1);
    chk("w32_byte0_dout", 32'(dout2),  32'({2'b00, 8'h0A}));
    chk("w32_busy_empty", 32'(empty2), 32'd0);
    #2;
    rst2 = 1'b1;
    #1;
    chk("arst_dout",  32'(dout2),  32'(c_comma));
    chk("arst_rdy",   32'(rdy2),   32'd0);
    chk("arst_empty", 32'(empty2), 32'd1);
    chk("arst_count", 32'(cnt2),   32'd0);
    chk("arst_full",  32'(full2),  32'd0);
    tick();
    rst2 = 1'b0;
    tick();
    rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    tick();
    chk("w32_after_rst_sb", 32'(sb2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_epath_tx_fifo_ser
`default_nettype wire
